// File: rtl/tank_pkg.sv
// ---------------------------------------------------------------------------
// tank_pkg
// Shared definitions for the VRAM arbiter / tile blitter.
//   - Bus widths for VRAM, Source_RAM, pixels and tile dimensions.
//   - Default screen stride and transparent key colour.
//   - Blitter FSM state encoding and VRAM owner encoding.
//   - key_match(): transparent-pixel test used by the blitter.
// ---------------------------------------------------------------------------
package tank_pkg;

    localparam int VADDR_W = 19;   // VRAM address width
    localparam int SADDR_W = 14;   // Source_RAM address width
    localparam int PIX_W   = 12;   // RGB444 pixel
    localparam int DIM_W   = 6;    // tile width/height minus 1

    localparam int               SCREEN_W_DEF  = 640;
    localparam logic [PIX_W-1:0] KEY_COLOR_DEF = 12'h000;

    // Blitter FSM: one pixel is read (RD), the read latency absorbed (LAT)
    // and the pixel written (WR); DONE is the single-cycle completion state.
    typedef enum logic [2:0] {
        BLIT_IDLE = 3'd0,
        BLIT_RD   = 3'd1,
        BLIT_LAT  = 3'd2,
        BLIT_WR   = 3'd3,
        BLIT_DONE = 3'd4
    } blit_state_e;

    // Who drives the VRAM port in a given cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_BLIT = 2'd3
    } vram_owner_e;

    // A pixel is skipped only when keying is enabled and it equals the key.
    function automatic logic key_match(input logic             key_en,
                                       input logic [PIX_W-1:0] pix,
                                       input logic [PIX_W-1:0] key);
        return key_en && (pix == key);
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// ---------------------------------------------------------------------------
// blit_addr_gen
// Source/destination pointer and row/column counters for one tile copy.
// The source tile is packed (stride = tile width), the destination uses the
// screen stride. All arithmetic wraps (2^14 source, 2^19 VRAM).
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears everything)
//   load         latch base addresses and dimensions, reset counters
//   step         one pixel finished; advance pointers
//   src_base     Source_RAM base of the tile
//   dst_base     VRAM address of the tile's top-left pixel
//   width_m1     tile width minus 1
//   height_m1    tile height minus 1
//   src_ptr      current Source_RAM address
//   dst_ptr      current VRAM address
//   last_pixel   current pixel is the bottom-right one of the tile
// ---------------------------------------------------------------------------
module blit_addr_gen
    import tank_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [SADDR_W-1:0] src_base,
    input  logic [VADDR_W-1:0] dst_base,
    input  logic [DIM_W-1:0]   width_m1,
    input  logic [DIM_W-1:0]   height_m1,
    output logic [SADDR_W-1:0] src_ptr,
    output logic [VADDR_W-1:0] dst_ptr,
    output logic               last_pixel
);

    localparam logic [VADDR_W-1:0] STRIDE = VADDR_W'(SCREEN_W);

    logic [VADDR_W-1:0] row_base;
    logic [DIM_W-1:0]   col_cnt;
    logic [DIM_W-1:0]   row_cnt;
    logic [DIM_W-1:0]   width_q;
    logic [DIM_W-1:0]   height_q;
    logic               row_end;

    assign row_end    = (col_cnt == width_q);
    assign last_pixel = row_end && (row_cnt == height_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            row_base <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else if (load) begin
            src_ptr  <= src_base;
            dst_ptr  <= dst_base;
            row_base <= dst_base;
            col_cnt  <= '0;
            row_cnt  <= '0;
            width_q  <= width_m1;
            height_q <= height_m1;
        end else if (step) begin
            src_ptr <= src_ptr + 1'b1;
            if (row_end) begin
                // Next row starts one screen line below the current row start.
                col_cnt  <= '0;
                row_cnt  <= row_cnt + 1'b1;
                dst_ptr  <= row_base + STRIDE;
                row_base <= row_base + STRIDE;
            end else begin
                col_cnt <= col_cnt + 1'b1;
                dst_ptr <= dst_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_blit_arb.sv
// ---------------------------------------------------------------------------
// vram_blit_arb
// Single-port VRAM arbiter with a tile blitter. Each cycle exactly one
// master owns the port, fixed priority VGA > CPU > blitter.
//
// Handshakes:
//   cpu_req is a level held until cpu_ack; cpu_ack pulses in the cycle the
//   write is placed on the port (same cycle as the grant). blit_start is a
//   one-cycle pulse honoured only while idle; blit_done pulses for one cycle
//   after the last pixel. Source_RAM data returns one clk after source_addr.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   vga_rdn, vga_addr         VGA scan-out read (active-low strobe)
//   cpu_req/addr/wdata/ack    CPU pixel write
//   blit_start/src/dst/w/h    tile copy request (w/h are size minus 1)
//   blit_key_en               skip KEY_COLOR pixels
//   blit_busy, blit_done      copy status
//   source_addr, source_out   Source_RAM read port
//   vram_addr/we/data_in      VRAM port
//   dbg_state                 blitter FSM state (blit_state_e encoding)
// ---------------------------------------------------------------------------
module vram_blit_arb
    import tank_pkg::*;
#(
    parameter int               SCREEN_W  = SCREEN_W_DEF,
    parameter logic [PIX_W-1:0] KEY_COLOR = KEY_COLOR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vga_rdn,
    input  logic [VADDR_W-1:0] vga_addr,
    input  logic               cpu_req,
    input  logic [VADDR_W-1:0] cpu_addr,
    input  logic [PIX_W-1:0]   cpu_wdata,
    output logic               cpu_ack,
    input  logic               blit_start,
    input  logic [SADDR_W-1:0] blit_src,
    input  logic [VADDR_W-1:0] blit_dst,
    input  logic [DIM_W-1:0]   blit_w,
    input  logic [DIM_W-1:0]   blit_h,
    input  logic               blit_key_en,
    output logic               blit_busy,
    output logic               blit_done,
    output logic [SADDR_W-1:0] source_addr,
    input  logic [PIX_W-1:0]   source_out,
    output logic [VADDR_W-1:0] vram_addr,
    output logic               vram_we,
    output logic [PIX_W-1:0]   vram_data_in,
    output logic [2:0]         dbg_state
);

    blit_state_e        state;
    logic [PIX_W-1:0]   pix_q;
    logic               key_en_q;
    logic               busy_q;
    logic               done_q;

    logic [SADDR_W-1:0] src_ptr;
    logic [VADDR_W-1:0] dst_ptr;
    logic               last_pixel;
    logic               ag_load;
    logic               ag_step;

    logic               key_skip;
    logic               blit_grant;
    logic               wr_fire;
    vram_owner_e        owner;

    // ------------------------------------------------------------------
    // WR completion: a keyed pixel finishes without touching the port;
    // otherwise the blitter needs the port free of both VGA and CPU.
    // ------------------------------------------------------------------
    assign key_skip   = key_match(key_en_q, pix_q, KEY_COLOR);
    assign blit_grant = vga_rdn && !cpu_req;
    assign wr_fire    = (state == BLIT_WR) && (key_skip || blit_grant);

    assign ag_load = (state == BLIT_IDLE) && blit_start;
    assign ag_step = wr_fire;

    blit_addr_gen #(
        .SCREEN_W (SCREEN_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (ag_load),
        .step       (ag_step),
        .src_base   (blit_src),
        .dst_base   (blit_dst),
        .width_m1   (blit_w),
        .height_m1  (blit_h),
        .src_ptr    (src_ptr),
        .dst_ptr    (dst_ptr),
        .last_pixel (last_pixel)
    );

    // ------------------------------------------------------------------
    // Blitter FSM with registered status outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BLIT_IDLE;
            pix_q    <= '0;
            key_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                BLIT_IDLE: begin
                    if (blit_start) begin
                        state    <= BLIT_RD;
                        key_en_q <= blit_key_en;
                        busy_q   <= 1'b1;
                    end
                end
                BLIT_RD: begin
                    state <= BLIT_LAT;
                end
                BLIT_LAT: begin
                    pix_q <= source_out;
                    state <= BLIT_WR;
                end
                BLIT_WR: begin
                    // Without a grant WR simply holds; pointers only move on wr_fire.
                    if (wr_fire) begin
                        if (last_pixel) begin
                            state  <= BLIT_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= BLIT_RD;
                        end
                    end
                end
                BLIT_DONE: begin
                    state  <= BLIT_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= BLIT_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // Status is forced low while reset is held so an aborted copy never
    // shows busy or done in the reset cycle itself.
    assign blit_busy   = busy_q && !rst;
    assign blit_done   = done_q && !rst;
    assign source_addr = src_ptr;
    assign dbg_state   = state;

    // ------------------------------------------------------------------
    // Port arbitration: VGA > CPU > blitter, purely combinational so the
    // VGA path and the CPU grant add no latency.
    // ------------------------------------------------------------------
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            if (!vga_rdn) begin
                owner = OWN_VGA;
            end else if (cpu_req) begin
                owner = OWN_CPU;
            end else if ((state == BLIT_WR) && !key_skip) begin
                owner = OWN_BLIT;
            end
        end
    end

    always_comb begin
        vram_addr    = vga_addr;
        vram_we      = 1'b0;
        vram_data_in = '0;
        cpu_ack      = 1'b0;
        case (owner)
            OWN_CPU: begin
                vram_addr    = cpu_addr;
                vram_data_in = cpu_wdata;
                vram_we      = 1'b1;
                cpu_ack      = 1'b1;
            end
            OWN_BLIT: begin
                vram_addr    = dst_ptr;
                vram_data_in = pix_q;
                vram_we      = 1'b1;
            end
            default: begin
                vram_addr    = vga_addr;
                vram_we      = 1'b0;
                vram_data_in = '0;
                cpu_ack      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vram_blit_arb.sv
// ---------------------------------------------------------------------------
// tb_vram_blit_arb
// Directed bench for vram_blit_arb: reset state, VGA/CPU priority, blit
// addressing and timing, colour keying, CPU contention, mid-copy reset,
// ignored restart and VRAM address wrap.
// ---------------------------------------------------------------------------
module tb_vram_blit_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_rdn = 1'b1;
    logic [18:0] vga_addr = '0;
    logic        cpu_req = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [11:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic        blit_start = 1'b0;
    logic [13:0] blit_src = '0;
    logic [18:0] blit_dst = '0;
    logic [5:0]  blit_w = '0;
    logic [5:0]  blit_h = '0;
    logic        blit_key_en = 1'b0;
    logic        blit_busy;
    logic        blit_done;
    logic [13:0] source_addr;
    logic [11:0] source_out = '0;
    logic [18:0] vram_addr;
    logic        vram_we;
    logic [11:0] vram_data_in;
    logic [2:0]  dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vram_blit_arb dut (
        .clk          (clk),
        .rst          (rst),
        .vga_rdn      (vga_rdn),
        .vga_addr     (vga_addr),
        .cpu_req      (cpu_req),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_ack      (cpu_ack),
        .blit_start   (blit_start),
        .blit_src     (blit_src),
        .blit_dst     (blit_dst),
        .blit_w       (blit_w),
        .blit_h       (blit_h),
        .blit_key_en  (blit_key_en),
        .blit_busy    (blit_busy),
        .blit_done    (blit_done),
        .source_addr  (source_addr),
        .source_out   (source_out),
        .vram_addr    (vram_addr),
        .vram_we      (vram_we),
        .vram_data_in (vram_data_in),
        .dbg_state    (dbg_state)
    );

    // Source_RAM model: one-clock read latency.
    logic [11:0] src_mem [0:16383];
    always @(posedge clk) source_out <= src_mem[source_addr];

    // ---------------- write monitor / scoreboard ----------------
    logic [30:0] wr_q[$];    // observed {addr, data}
    logic [30:0] exp_q[$];   // expected {addr, data}
    logic [11:0] vmem [logic [18:0]];
    int          done_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            if (vram_we) begin
                wr_q.push_back({vram_addr, vram_data_in});
                vmem[vram_addr] = vram_data_in;
            end
            if (blit_done) done_cnt++;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wr_q.delete();
        exp_q.delete();
        vmem.delete();
        done_cnt = 0;
    endtask

    // Pulses blit_start for one cycle; returns in the cycle after the pulse.
    task automatic start_blit(input logic [13:0] src, input logic [18:0] dst,
                              input logic [5:0] w, input logic [5:0] h, input logic key);
        blit_src    = src;
        blit_dst    = dst;
        blit_w      = w;
        blit_h      = h;
        blit_key_en = key;
        blit_start  = 1'b1;
        tick();
        blit_start  = 1'b0;
    endtask

    // Counts cycles (current cycle = 1) until blit_done; bounded.
    task automatic wait_done(input int budget, output int cyc);
        cyc = -1;
        for (int n = 1; n <= budget; n++) begin
            #1;
            if (blit_done) begin
                cyc = n;
                break;
            end
            tick();
        end
        if (cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), {1'b0, wr_q[i]}, {1'b0, exp_q[i]});
    endtask

    // ---------------- stimulus ----------------
    int cyc;

    initial begin
        for (int i = 0; i < 16384; i++) src_mem[i] = 12'h000;
        src_mem[14'h0100] = 12'hA01;
        src_mem[14'h0101] = 12'hA02;
        src_mem[14'h0102] = 12'hA03;
        src_mem[14'h0103] = 12'hA04;
        src_mem[14'h0200] = 12'h123;
        src_mem[14'h0201] = 12'h000;
        src_mem[14'h0202] = 12'h456;
        src_mem[14'h0203] = 12'h789;
        src_mem[14'h3FF0] = 12'h1F1;
        src_mem[14'h0000] = 12'h5A5;
        done_cnt = 0;

        // ---- reset state ----
        vga_addr = 19'h12345;
        repeat (3) tick();
        check("rst_busy", blit_busy, 0);
        check("rst_ack", cpu_ack, 0);
        rst = 1'b0;
        tick();
        #1;
        check("idle_busy", blit_busy, 0);
        check("idle_done", blit_done, 0);
        check("idle_we", vram_we, 0);
        check("idle_addr", vram_addr, 19'h12345);
        check("idle_data", vram_data_in, 0);
        check("idle_srcaddr", source_addr, 0);
        check("idle_state", dbg_state, 0);

        // ---- VGA holds off CPU for 10 cycles ----
        clear_log();
        cpu_req   = 1'b1;
        cpu_addr  = 19'h00ABC;
        cpu_wdata = 12'h3C3;
        vga_rdn   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            vga_addr = 19'h00100 + 19'(i);
            #1;
            check($sformatf("vga_we%0d", i), vram_we, 0);
            check($sformatf("vga_ack%0d", i), cpu_ack, 0);
            check($sformatf("vga_addr%0d", i), vram_addr, 19'h00100 + 19'(i));
            tick();
        end
        vga_rdn = 1'b1;
        #1;
        check("cpu_ack_first", cpu_ack, 1);
        check("cpu_we_first", vram_we, 1);
        check("cpu_addr_first", vram_addr, 19'h00ABC);
        check("cpu_data_first", vram_data_in, 12'h3C3);
        tick();
        cpu_req = 1'b0;
        #1;
        check("cpu_released_we", vram_we, 0);
        tick();

        // ---- uncontended 2x2 blit ----
        clear_log();
        start_blit(14'h0100, 19'h00000, 6'd1, 6'd1, 1'b0);
        #1;
        check("b22_busy", blit_busy, 1);
        check("b22_srcaddr", source_addr, 14'h0100);
        wait_done(40, cyc);
        check("b22_done_cycle", cyc, 13);
        tick();
        #1;
        check("b22_done_pulse", blit_done, 0);
        check("b22_busy_after", blit_busy, 0);
        exp_q.push_back({19'h00000, 12'hA01});
        exp_q.push_back({19'h00001, 12'hA02});
        exp_q.push_back({19'h00280, 12'hA03});
        exp_q.push_back({19'h00281, 12'hA04});
        compare_writes("b22");

        // ---- 1x1 blit timing ----
        clear_log();
        start_blit(14'h0103, 19'h00500, 6'd0, 6'd0, 1'b0);
        wait_done(20, cyc);
        check("b11_done_cycle", cyc, 4);
        tick();
        exp_q.push_back({19'h00500, 12'hA04});
        compare_writes("b11");

        // ---- colour key skips 12'h000 ----
        clear_log();
        start_blit(14'h0200, 19'h01000, 6'd1, 6'd1, 1'b1);
        wait_done(40, cyc);
        check("key_done_cycle", cyc, 13);
        tick();
        exp_q.push_back({19'h01000, 12'h123});
        exp_q.push_back({19'h01280, 12'h456});
        exp_q.push_back({19'h01281, 12'h789});
        compare_writes("key");
        check("key_skipped_addr", vmem.exists(19'h01001), 0);

        // ---- CPU contention stalls the blitter in WR ----
        clear_log();
        for (int i = 0; i < 20; i++) begin
            cpu_req   = 1'b1;
            cpu_addr  = 19'h40000 + 19'(i);
            cpu_wdata = 12'h800 + 12'(i);
            if (i == 0) begin
                blit_src    = 14'h0100;
                blit_dst    = 19'h02000;
                blit_w      = 6'd1;
                blit_h      = 6'd1;
                blit_key_en = 1'b0;
                blit_start  = 1'b1;
            end
            #1;
            check($sformatf("cont_ack%0d", i), cpu_ack, 1);
            if (i == 19) begin
                check("cont_state_wr", dbg_state, 3);
                check("cont_busy", blit_busy, 1);
            end
            tick();
            blit_start = 1'b0;
        end
        cpu_req = 1'b0;
        wait_done(40, cyc);
        check("cont_done_cycle", cyc, 11);
        tick();
        check("cont_count", wr_q.size(), 24);
        for (int i = 0; i < 20; i++)
            check($sformatf("cont_cpu%0d", i),
                  vmem.exists(19'h40000 + 19'(i)) ? vmem[19'h40000 + 19'(i)] : 12'hFFF,
                  12'h800 + 12'(i));
        check("cont_b0", vmem.exists(19'h02000) ? vmem[19'h02000] : 12'hFFF, 12'hA01);
        check("cont_b1", vmem.exists(19'h02001) ? vmem[19'h02001] : 12'hFFF, 12'hA02);
        check("cont_b2", vmem.exists(19'h02280) ? vmem[19'h02280] : 12'hFFF, 12'hA03);
        check("cont_b3", vmem.exists(19'h02281) ? vmem[19'h02281] : 12'hFFF, 12'hA04);

        // ---- reset mid-blit ----
        clear_log();
        start_blit(14'h0100, 19'h03000, 6'd3, 6'd3, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check("mrst_busy_in_rst", blit_busy, 0);
        check("mrst_we_in_rst", vram_we, 0);
        tick();
        rst = 1'b0;
        #1;
        check("mrst_busy_after", blit_busy, 0);
        check("mrst_state", dbg_state, 0);
        check("mrst_srcaddr", source_addr, 0);
        repeat (20) tick();
        check("mrst_no_done", done_cnt, 0);
        clear_log();
        start_blit(14'h0102, 19'h03100, 6'd0, 6'd0, 1'b0);
        wait_done(20, cyc);
        check("mrst_new_done_cycle", cyc, 4);
        tick();
        exp_q.push_back({19'h03100, 12'hA03});
        compare_writes("mrst_new");

        // ---- ignored restart + 64x64 copy wrapping VRAM ----
        clear_log();
        start_blit(14'h3FF0, 19'h7FFFF, 6'd63, 6'd63, 1'b0);
        tick();
        blit_src   = 14'h0200;
        blit_dst   = 19'h12345;
        blit_w     = 6'd0;
        blit_h     = 6'd0;
        blit_start = 1'b1;
        tick();
        blit_start = 1'b0;
        wait_done(13000, cyc);
        check("wrap_done_cycle", cyc + 2, 12289);
        tick();
        check("wrap_count", wr_q.size(), 4096);
        check("wrap_done_cnt", done_cnt, 1);
        if (wr_q.size() == 4096) begin
            check("wrap_addr0", wr_q[0][30:12], 19'h7FFFF);
            check("wrap_data0", wr_q[0][11:0], 12'h1F1);
            check("wrap_addr1", wr_q[1][30:12], 19'h00000);
            check("wrap_data16", wr_q[16][11:0], 12'h5A5);
            check("wrap_addr64", wr_q[64][30:12], 19'h0027F);
            check("wrap_addr_last", wr_q[4095][30:12], 19'h09DBE);
        end
        check("wrap_no_restart", vmem.exists(19'h12345), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_blit_arb.md
VRAM_BLIT_ARB -- requirements
Module: vram_blit_arb

Interface
REQ-001 Parameter SCREEN_W, default 640, sets the VRAM row stride in pixels.
REQ-002 Parameter KEY_COLOR, default 12'h000, is the transparent source colour.
REQ-003 clk  input  1  system clock (100 MHz domain); reset is synchronous and active-high.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 vga_rdn  input  1  VGA read strobe, active low.
REQ-006 vga_addr  input  19  VGA scan-out VRAM address.
REQ-007 cpu_req  input  1  CPU pixel-write request, level, held until cpu_ack.
REQ-008 cpu_addr  input  19  CPU write address.
REQ-009 cpu_wdata  input  12  CPU write pixel (RGB444).
REQ-010 cpu_ack  output  1  one-cycle pulse in the cycle the CPU write is issued.
REQ-011 blit_start  input  1  one-cycle pulse that starts a tile copy.
REQ-012 blit_src  input  14  Source_RAM base address of the tile.
REQ-013 blit_dst  input  19  VRAM address of the tile's top-left pixel.
REQ-014 blit_w  input  6  tile width minus 1 (1..64 pixels).
REQ-015 blit_h  input  6  tile height minus 1 (1..64 rows).
REQ-016 blit_key_en  input  1  enables skipping of KEY_COLOR pixels.
REQ-017 blit_busy  output  1  high while a copy is in progress.
REQ-018 blit_done  output  1  one-cycle pulse after the last pixel.
REQ-019 source_addr  output  14  Source_RAM read address.
REQ-020 source_out  input  12  Source_RAM data, valid one clk after source_addr.
REQ-021 vram_addr  output  19  VRAM port address.
REQ-022 vram_we  output  1  VRAM write enable.
REQ-023 vram_data_in  output  12  VRAM write data.

Function
REQ-024 Fixed priority per cycle: VGA (vga_rdn=0) > CPU > blitter; there is exactly one VRAM owner per cycle.
REQ-025 VGA cycle: vram_addr=vga_addr, vram_we=0, combinational pass-through with zero added latency.
REQ-026 CPU grant (cpu_req=1, vga_rdn=1): vram_addr=cpu_addr, vram_data_in=cpu_wdata, vram_we=1, cpu_ack=1 in the same cycle.
REQ-027 A CPU request that overlaps VGA cycles stalls without loss, and is issued in the first cycle with vga_rdn=1.
REQ-028 Blitter FSM states: IDLE, RD, LAT, WR, DONE.
REQ-029 FSM transitions: IDLE -> RD on blit_start; RD -> LAT; LAT -> WR; WR -> RD for the next pixel or -> DONE after the last pixel; DONE -> IDLE.
REQ-030 In IDLE, blit_start latches all blit_* inputs; blit_start while busy is ignored.
REQ-031 RD drives source_addr = src_ptr; LAT registers source_out into pix_q.
REQ-032 WR issues the write only when neither VGA nor CPU owns the port; otherwise WR holds with its pointers unchanged.
REQ-033 WR with blit_key_en=1 and pix_q=KEY_COLOR completes without asserting vram_we and needs no grant.
REQ-034 Pointer update after each WR: src_ptr+1 (packed tile, stride = width).
REQ-035 Destination pointer update: dst_ptr+1 within a row; at row end, dst_ptr = row_base+SCREEN_W and row_base updates to the same value.
REQ-036 Address arithmetic is unsigned and wraps modulo 2^14 (source) and 2^19 (VRAM); there is no bounds check.
REQ-037 The minimum cost is 3 clk per pixel; a 1x1 copy asserts blit_done 4 clk after blit_start when uncontended.
REQ-038 blit_busy is high from the cycle after blit_start through DONE; blit_done is asserted in DONE only.
REQ-039 Idle defaults: vram_we=0, vram_addr=vga_addr, vram_data_in=0, source_addr=src_ptr.

Reset
REQ-040 When rst=1 at a clk edge, the FSM goes to IDLE and all pointers, counters and pix_q clear to 0.
REQ-041 cpu_ack, blit_busy and blit_done are 0 during reset, and reset aborts any copy in progress with no blit_done pulse.

Structure
REQ-042 The FSM state encoding and the SCREEN_W/KEY_COLOR defaults live in the shared package tank_pkg.
REQ-043 The one natural sub-module is blit_addr_gen (the src/dst/row counters); the arbitration mux stays in the top level.

Verification
REQ-044 Hold vga_rdn=0 for 10 cycles with cpu_req=1 -> vram_we=0 throughout, then cpu_ack and vram_we are asserted in the first cycle with vga_rdn=1.
REQ-045 Uncontended 2x2 blit with src=0x0100 and dst=0x00000 -> writes to 0x00000, 0x00001, 0x00280, 0x00281, then blit_done at cycle 13.
REQ-046 key_en=1 with a source pixel of 12'h000 -> that address is never written; the other pixels are written correctly.
REQ-047 cpu_req asserted continuously during a blit -> each CPU write acked within 1 cycle, the blit stalls in WR, and the final VRAM contents match the reference model.
REQ-048 rst pulse mid-blit -> blit_busy=0 next cycle, no blit_done; a new blit_start then runs normally.
REQ-049 blit_start while busy and a 64x64 copy at dst=0x7FFFF -> the second start is ignored and the addresses wrap modulo 2^19.
